// File: rtl/fir_stim_feeder_if.sv
// Sample-write handshake between a stimulus source and the FIR feeder.
interface fir_stim_feeder_if #(
  parameter int DATA_W = 11
);
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_valid;
  logic                     wr_last;
  logic                     wr_ready;

  modport master (output wr_data, output wr_valid, output wr_last, input wr_ready);
  modport slave  (input wr_data, input wr_valid, input wr_last, output wr_ready);
endinterface

// File: rtl/fir_stim_feeder.sv
// Buffers a sample stream in a small FIFO and replays it to a FIR input with
// programmable idle gaps, holds the coefficient bank, and flags end of run.
module fir_stim_feeder #(
  parameter int DATA_W = 11,
  parameter int COEF_W = 11,
  parameter int DEPTH  = 8,
  parameter int DRAIN  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_stim_feeder_if.slave         wr,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  input  logic [1:0]               gap,
  output logic signed [DATA_W-1:0] dout,
  output logic                     vout,
  output logic signed [COEF_W-1:0] h0,
  output logic signed [COEF_W-1:0] h1,
  output logic signed [COEF_W-1:0] h2,
  output logic signed [COEF_W-1:0] h3,
  output logic signed [COEF_W-1:0] h4,
  output logic signed [COEF_W-1:0] h5,
  output logic signed [COEF_W-1:0] h6,
  output logic signed [COEF_W-1:0] h7,
  output logic signed [COEF_W-1:0] h8,
  output logic                     end_sim
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [DATA_W:0]    mem [DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [CW-1:0]      count;
  logic [1:0]         gap_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic signed [COEF_W-1:0] coef [9];
  logic               accepting, push, pop;

  assign accepting   = (state == S_IDLE) || (state == S_EMIT) || (state == S_GAP);
  // Held low while reset is asserted, not just once the state settles.
  assign wr.wr_ready = rst_n && accepting && (count < CW'(DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  assign end_sim     = (state == S_DONE);

  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE, S_EMIT: begin
        if (count != '0) begin
          pop = 1'b1;
          if (mem[rptr][DATA_W])   state_nxt = S_DRAIN;
          else if (gap != 2'd0)    state_nxt = S_GAP;
          else                     state_nxt = S_EMIT;
        end
      end
      S_GAP:   if (gap_cnt == 2'd1) state_nxt = S_EMIT;
      S_DRAIN: if (drain_cnt == DCW'(DRAIN - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FIFO storage carries no reset; pointers and occupancy define its content.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wr.wr_last, wr.wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
      vout      <= 1'b0;
      dout      <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop)                  gap_cnt <= gap;
      else if (state == S_GAP)  gap_cnt <= gap_cnt - 2'd1;
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DCW'(1);
      else                  drain_cnt <= '0;
      vout <= pop;
      if (pop) dout <= $signed(mem[rptr][DATA_W-1:0]);
    end
  end

  // Coefficients are writable only before the first sample leaves IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) coef[k] <= '0;
    end else if (cfg_we && (state == S_IDLE)) begin
      for (int k = 0; k < 9; k++)
        if (cfg_addr == 4'(k)) coef[k] <= cfg_data;
    end
  end

  assign h0 = coef[0];
  assign h1 = coef[1];
  assign h2 = coef[2];
  assign h3 = coef[3];
  assign h4 = coef[4];
  assign h5 = coef[5];
  assign h6 = coef[6];
  assign h7 = coef[7];
  assign h8 = coef[8];

endmodule
